// File: rtl/mod179_sched_pkg.sv
// mod179_sched_pkg: shared state encoding and widths for the mod179 scheduler
package mod179_sched_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10
    } state_t;
    localparam logic [7:0] MOD179_M = 8'd179;
    localparam int OP_W  = 16;
    localparam int RES_W = 8;
endpackage

// File: rtl/mod179_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first set request at or after ptr
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] winner,
    output logic                 valid
);
    localparam int PW = $clog2(N);
    // scan from the farthest offset down so the closest request to ptr wins
    always_comb begin
        winner = '0;
        valid  = |req;
        for (int k = N - 1; k >= 0; k--)
            if (req[(int'(ptr) + k) % N]) winner = PW'((int'(ptr) + k) % N);
    end
endmodule

// File: rtl/mod179_sched.sv
// mod179_sched: round-robin sharing of one mod179 engine among NREQ requesters
module mod179_sched
    import mod179_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NREQ-1:0]    req,
    input  logic [OP_W*NREQ-1:0] x_in,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [RES_W-1:0]   rsp_z,
    output logic               busy,
    output logic               err,
    output logic               eng_start,
    output logic [OP_W-1:0]    eng_x,
    input  logic               eng_done,
    input  logic [RES_W-1:0]   eng_z
);
    localparam int PW = $clog2(NREQ);
    localparam int WD = $clog2(TIMEOUT) + 1;
    state_t          state;
    logic [PW-1:0]   ptr, owner, winner, next_ptr;
    logic            win_valid;
    logic [WD-1:0]   wdog;
    logic [NREQ-1:0] owner_oh;
    rr_arbiter #(.N(NREQ)) u_arb (
        .req    (req),
        .ptr    (ptr),
        .winner (winner),
        .valid  (win_valid)
    );
    assign owner_oh  = {{(NREQ-1){1'b0}}, 1'b1} << owner;
    assign next_ptr  = (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;
    assign eng_start = state == ISSUE;
    assign gnt       = eng_start ? owner_oh : '0;
    assign busy      = state != IDLE;
    // job FSM: pick, issue, wait for done or watchdog, return result to owner
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            eng_x     <= '0;
            rsp_z     <= '0;
            rsp_valid <= '0;
            wdog      <= '0;
            err       <= 1'b0;
        end else begin
            rsp_valid <= '0;
            case (state)
                IDLE: if (win_valid) begin
                    owner <= winner;
                    eng_x <= x_in[OP_W*winner +: OP_W];
                    wdog  <= '0;
                    state <= ISSUE;
                end
                ISSUE: state <= WAIT;
                WAIT: if (eng_done) begin
                    rsp_z     <= eng_z;
                    rsp_valid <= owner_oh;
                    ptr       <= next_ptr;
                    state     <= IDLE;
                end else if (wdog == WD'(TIMEOUT - 1)) begin
                    err       <= 1'b1;
                    rsp_z     <= '0;
                    rsp_valid <= owner_oh;
                    ptr       <= next_ptr;
                    state     <= IDLE;
                end else begin
                    wdog <= (&wdog) ? wdog : wdog + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mod179_sched.sv
// tb_mod179_sched: directed checks of the scheduler against a behavioural mod179 engine
module tb_mod179_sched;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  req = '0;
    logic [63:0] x_in = '0;
    logic [3:0]  gnt, rsp_valid;
    logic [7:0]  rsp_z, eng_z;
    logic        busy, err, eng_start, eng_done;
    logic [15:0] eng_x;
    logic        hang = 1'b0, inj_done = 1'b0, done_r;
    logic [7:0]  z_r;
    logic [15:0] x_l;
    logic [2:0]  cnt;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    mod179_sched #(.NREQ(4), .TIMEOUT(64)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .x_in(x_in), .gnt(gnt),
        .rsp_valid(rsp_valid), .rsp_z(rsp_z), .busy(busy), .err(err),
        .eng_start(eng_start), .eng_x(eng_x), .eng_done(eng_done), .eng_z(eng_z)
    );

    // engine stand-in: answers 3 cycles after start unless hung
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= 0; done_r <= 0; z_r <= 0; x_l <= 0;
        end else begin
            done_r <= 0;
            if (eng_start && !hang) begin
                cnt <= 3; x_l <= eng_x;
            end else if (cnt != 0) begin
                cnt <= cnt - 1;
                if (cnt == 1) begin done_r <= 1; z_r <= 8'(x_l % 179); end
            end
        end
    end
    assign eng_done = done_r | inj_done;
    assign eng_z    = done_r ? z_r : 8'hEE;

    task automatic step;
        @(posedge clk); #1;
    endtask

    task automatic do_reset;
        reset_n = 0; req = '0; x_in = '0; hang = 0; inj_done = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        step;
    endtask

    task automatic wait_gnt(output logic [3:0] g);
        g = '0;
        for (int i = 0; i < 20 && g == 0; i++) begin step; g = gnt; end
    endtask

    task automatic wait_rsp(output logic [3:0] v, output logic [7:0] z);
        v = '0; z = '0;
        for (int i = 0; i < 200 && v == 0; i++) begin step; v = rsp_valid; z = rsp_z; end
    endtask

    task automatic do_job(input int i, input logic [15:0] x,
                          output logic [3:0] g, output logic [3:0] v, output logic [7:0] z);
        req = '0; req[i] = 1'b1; x_in[16*i +: 16] = x;
        wait_gnt(g);
        req = '0;
        wait_rsp(v, z);
    endtask

    task automatic test_reset;
        reset_n = 0; #1;
        checks++;
        if ({gnt, rsp_valid, rsp_z, busy, err, eng_start, eng_x} !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0", {gnt, rsp_valid, rsp_z, busy, err, eng_start, eng_x});
        end
        do_reset;
    endtask

    task automatic test_single;
        logic [3:0] v; logic [7:0] z;
        do_reset;
        req = 4'b0001; x_in[15:0] = 16'h1234;
        step;
        checks++;
        if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt: got %b expected 0001", gnt); end
        req = '0;
        step;
        checks++;
        if (gnt !== 4'b0000) begin errors++; $display("FAIL single_gnt_pulse: got %b expected 0000", gnt); end
        wait_rsp(v, z);
        checks++;
        if (v !== 4'b0001 || z !== 8'd6) begin errors++; $display("FAIL single_rsp: got %b/%0d expected 0001/6", v, z); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b expected 0", busy); end
        step;
        checks++;
        if (rsp_valid !== 4'b0000 || rsp_z !== 8'd6) begin errors++; $display("FAIL single_hold: got %b/%0d expected 0000/6", rsp_valid, rsp_z); end
    endtask

    task automatic test_values;
        logic [15:0] xs [5] = '{16'hFFFF, 16'd179, 16'd500, 16'd178, 16'd0};
        logic [7:0]  es [5] = '{8'd21, 8'd0, 8'd142, 8'd178, 8'd0};
        logic [3:0] g, v; logic [7:0] z;
        do_reset;
        for (int k = 0; k < 5; k++) begin
            do_job(2, xs[k], g, v, z);
            checks++;
            if (g !== 4'b0100 || v !== 4'b0100 || z !== es[k]) begin
                errors++; $display("FAIL value_%0d: got gnt %b rsp %b z %0d expected 0100/0100/%0d", k, g, v, z, es[k]);
            end
        end
    endtask

    task automatic test_fairness_back_to_back;
        logic [7:0] es [4] = '{8'd105, 8'd106, 8'd107, 8'd108};
        int ng = 0, nr = 0;
        bit prev_rsp = 0;
        do_reset;
        x_in = {16'd1003, 16'd1002, 16'd1001, 16'd1000};
        req = 4'b1111;
        for (int c = 0; c < 400 && nr < 8; c++) begin
            step;
            if (prev_rsp) begin
                checks++;
                if (gnt === 4'b0000) begin errors++; $display("FAIL back_to_back_%0d: got gnt 0000 expected a grant", nr); end
            end
            prev_rsp = 0;
            if (gnt !== 0) begin
                checks++;
                if (gnt !== 4'(1 << (ng % 4))) begin errors++; $display("FAIL fair_gnt_%0d: got %b expected %b", ng, gnt, 4'(1 << (ng % 4))); end
                ng++;
            end
            if (rsp_valid !== 0) begin
                checks++;
                if (rsp_valid !== 4'(1 << (nr % 4)) || rsp_z !== es[nr % 4]) begin
                    errors++; $display("FAIL fair_rsp_%0d: got %b/%0d expected %b/%0d", nr, rsp_valid, rsp_z, 4'(1 << (nr % 4)), es[nr % 4]);
                end
                nr++; prev_rsp = 1;
            end
        end
        req = '0;
        checks++;
        if (nr != 8) begin errors++; $display("FAIL fair_count: got %0d responses expected 8", nr); end
    endtask

    task automatic test_ptr_wrap;
        logic [3:0] g, v; logic [7:0] z;
        do_reset;
        do_job(3, 16'd7, g, v, z);
        x_in[15:0] = 16'd10; x_in[63:48] = 16'd20;
        req = 4'b1001;
        wait_gnt(g);
        checks++;
        if (g !== 4'b0001) begin errors++; $display("FAIL wrap_first: got %b expected 0001", g); end
        req = 4'b1000;
        wait_rsp(v, z);
        checks++;
        if (v !== 4'b0001 || z !== 8'd10) begin errors++; $display("FAIL wrap_rsp0: got %b/%0d expected 0001/10", v, z); end
        wait_gnt(g);
        req = '0;
        wait_rsp(v, z);
        checks++;
        if (g !== 4'b1000 || v !== 4'b1000 || z !== 8'd20) begin errors++; $display("FAIL wrap_second: got %b/%b/%0d expected 1000/1000/20", g, v, z); end
    endtask

    task automatic test_req_drop;
        logic [3:0] v; logic [7:0] z;
        do_reset;
        inj_done = 1; step; inj_done = 0;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 4'b0000) begin errors++; $display("FAIL idle_done_ignored: got busy %b rsp %b expected 0/0000", busy, rsp_valid); end
        x_in[15:0] = 16'd400; req = 4'b0001;
        step;
        req = '0;
        wait_rsp(v, z);
        checks++;
        if (v !== 4'b0001 || z !== 8'd42) begin errors++; $display("FAIL req_drop: got %b/%0d expected 0001/42", v, z); end
    endtask

    task automatic test_watchdog;
        logic [3:0] g, v; logic e64; int n;
        do_reset;
        hang = 1;
        x_in[31:16] = 16'd500; req = 4'b0010;
        wait_gnt(g);
        req = '0;
        e64 = 1'bx;
        for (n = 1; n <= 200; n++) begin
            step;
            if (n == 64) e64 = err;
            if (rsp_valid !== 0) break;
        end
        checks++;
        if (n != 65 || e64 !== 1'b0) begin errors++; $display("FAIL wdog_timing: got %0d cycles err_before %b expected 65/0", n, e64); end
        checks++;
        if (err !== 1'b1 || rsp_valid !== 4'b0010 || rsp_z !== 8'd0) begin
            errors++; $display("FAIL wdog_rsp: got err %b rsp %b z %0d expected 1/0010/0", err, rsp_valid, rsp_z);
        end
        x_in[47:32] = 16'd9; req = 4'b0100;
        wait_gnt(g);
        req = '0;
        repeat (10) step;
        checks++;
        if (g !== 4'b0100 || busy !== 1'b1 || err !== 1'b1) begin errors++; $display("FAIL after_err: got gnt %b busy %b err %b expected 0100/1/1", g, busy, err); end
        reset_n = 0; #1;
        checks++;
        if ({gnt, rsp_valid, rsp_z, busy, err, eng_start, eng_x} !== '0) begin
            errors++; $display("FAIL midwait_reset: got %h expected 0", {gnt, rsp_valid, rsp_z, busy, err, eng_start, eng_x});
        end
        step; reset_n = 1; hang = 0;
        v = '0;
        for (int i = 0; i < 80; i++) begin step; v = v | rsp_valid; end
        checks++;
        if (v !== 4'b0000) begin errors++; $display("FAIL dropped_job: got rsp %b expected 0000", v); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_values;
        test_fairness_back_to_back;
        test_ptr_wrap;
        test_req_drop;
        test_watchdog;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
